// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used as the bit-slice of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell, LSB first, result after WIDTH RUN cycles.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] sh_sum;
    logic [WIDTH-1:0] sum_next;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_cout;
    logic             accept;
    logic             last_bit;

    full_adder u_fa (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands in place.
    assign sum_next = {fa_s, {(WIDTH-1){1'b0}}} | (sh_sum >> 1);
    assign accept   = start && (state != S_RUN);
    assign last_bit = (state == S_RUN) && (cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (cnt == LAST_BIT) state_next = S_DONE;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a   <= '0;
            sh_b   <= '0;
            sh_sum <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (accept) begin
            sh_a  <= a;
            sh_b  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == S_RUN) begin
            sh_a   <= sh_a >> 1;
            sh_b   <= sh_b >> 1;
            sh_sum <= sum_next;
            carry  <= fa_cout;
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                sum  <= sum_next;
                cout <= fa_cout;
            end
        end
    end

endmodule
